// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundles and the handshake interface
// between the memory stage and a data-bus slave.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] data;
        logic [7:0]  strobe;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

interface dbus_sram_responder_if;
    import dbus_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (
        output dreq,
        input  dresp
    );

    modport slave (
        input  dreq,
        output dresp
    );
endinterface

// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus slave backed by a word-wide SRAM with
// programmable response latency, byte-lane writes and error flags.
module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_sram_responder_if.slave  bus,
    output logic                  err_oob,
    output logic                  proto_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [63:0]   addr_q;
    logic [63:0]   data_q;
    logic [7:0]    strobe_q;
    logic          inr_q;
    logic [AW-1:0] idx_q;
    logic          accept;

    logic [63:0]   mem [DEPTH_WORDS];

    logic [63:0]   off;
    logic          inr;
    logic [AW-1:0] idx;
    logic          mismatch;

    assign off = bus.dreq.addr - BASE_ADDR;
    assign inr = (bus.dreq.addr >= BASE_ADDR) && (off < SPAN);
    assign idx = off[AW+2:3];

    assign mismatch = (bus.dreq.addr   != addr_q)
                   || (bus.dreq.data   != data_q)
                   || (bus.dreq.strobe != strobe_q);

    // Size and sub-word address bits never affect the array access.
    logic unused_ok;
    assign unused_ok = ^{bus.dreq.size};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            inr_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q   <= bus.dreq.addr;
                data_q   <= bus.dreq.data;
                strobe_q <= bus.dreq.strobe;
                inr_q    <= inr;
                idx_q    <= idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.dreq.valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.dreq.valid) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read returns the pre-write word; the write lands on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && inr_q) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (state_q != IDLE && bus.dreq.valid && mismatch) begin
            proto_err <= 1'b1;
        end
    end

    always_comb begin
        bus.dresp.addr_ok = (state_q == RESP);
        bus.dresp.data_ok = (state_q == RESP);
        bus.dresp.data    = '0;
        if (state_q == RESP && inr_q) begin
            bus.dresp.data = mem[idx_q];
        end
        err_oob = (state_q == RESP) && !inr_q;
    end
endmodule
